// File: rtl/test_pattern_pkg.sv
// Definitions shared by the test pattern generator and checker: FSM encoding,
// payload field layout and default frame constants.
package test_pattern_pkg;

    localparam logic [7:0]  TYPE_FLAG_DEFAULT = 8'hA5;
    localparam logic [15:0] ETH_TYPE_DEFAULT  = 16'h88B5;

    // Byte offsets of the payload fields (big-endian multi-byte fields)
    localparam int OFS_FLAG  = 0;
    localparam int OFS_TS    = 1;
    localparam int OFS_ZEROS = 3;
    localparam int OFS_PNUM  = 6;
    localparam int OFS_DATA  = 8;

    localparam int FLAG_LEN  = OFS_TS - OFS_FLAG;
    localparam int TS_LEN    = OFS_ZEROS - OFS_TS;
    localparam int ZEROS_LEN = OFS_PNUM - OFS_ZEROS;
    localparam int PNUM_LEN  = OFS_DATA - OFS_PNUM;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TYPE_FLAG,
        S_TIMESTAMP,
        S_3ZEROS,
        S_PACKET_NUM,
        S_DATA,
        S_DROP
    } state_t;

    typedef struct packed {
        logic seq;
        logic data;
        logic len;
        logic frame;
    } frame_err_t;

    function automatic logic [7:0] data_byte(input logic [7:0] idx);
        return idx;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/test_check_pattern.sv
// Receive-side checker for test pattern frames: filters on MAC/ethertype, parses
// the payload fields and keeps saturating sequence/content/length/frame counters.
module test_check_pattern
    import test_pattern_pkg::*;
#(
    parameter int          DATA_LENGTH = 64,
    parameter int          DATA_WIDTH  = 8,
    parameter logic [7:0]  TYPE_FLAG   = TYPE_FLAG_DEFAULT,
    parameter logic [15:0] ETH_TYPE    = ETH_TYPE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [47:0]           local_mac,
    input  logic [47:0]           peer_mac,
    input  logic                  clear_counters,
    input  logic                  s_eth_hdr_valid,
    output logic                  s_eth_hdr_ready,
    input  logic [47:0]           s_eth_dest_mac,
    input  logic [47:0]           s_eth_src_mac,
    input  logic [15:0]           s_eth_type,
    input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
    input  logic                  s_eth_payload_axis_tvalid,
    output logic                  s_eth_payload_axis_tready,
    input  logic                  s_eth_payload_axis_tlast,
    input  logic                  s_eth_payload_axis_tuser,
    output logic [31:0]           rx_good_count,
    output logic [31:0]           err_seq_count,
    output logic [31:0]           err_data_count,
    output logic [31:0]           err_len_count,
    output logic [31:0]           err_frame_count,
    output logic [15:0]           last_packet_num,
    output logic [15:0]           last_timestamp,
    output logic                  pkt_done,
    output logic                  pkt_ok
);

    localparam logic [15:0] DATA_LAST = 16'(DATA_LENGTH - 1);

    state_t      state, state_n;
    frame_err_t  err_q, err_n;
    logic [15:0] cnt;
    logic [15:0] ts_shift;
    logic [7:0]  pnum_hi;
    logic [7:0]  rx_byte;
    logic [15:0] pnum_full;
    logic        armed, drain_report;
    logic        beat, hdr_beat, hdr_match, parsing, last_data;
    logic        mismatch, pnum_commit, frame_end, frame_ok;

    assign rx_byte                   = s_eth_payload_axis_tdata[7:0];
    assign pnum_full                 = {pnum_hi, rx_byte};
    assign s_eth_hdr_ready           = (state == S_IDLE);
    assign s_eth_payload_axis_tready = (state != S_IDLE);
    assign beat      = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
    assign hdr_beat  = s_eth_hdr_valid && s_eth_hdr_ready;
    assign hdr_match = (s_eth_dest_mac == local_mac) && (s_eth_src_mac == peer_mac)
                       && (s_eth_type == ETH_TYPE);
    assign parsing   = (state != S_IDLE) && (state != S_DROP);
    assign last_data = (state == S_DATA) && (cnt == DATA_LAST);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        state_n     = state;
        err_n       = err_q;
        mismatch    = 1'b0;
        pnum_commit = 1'b0;
        frame_end   = 1'b0;
        case (state)
            S_IDLE: if (hdr_beat) begin
                err_n   = '0;
                state_n = hdr_match ? S_TYPE_FLAG : S_DROP;
            end
            S_TYPE_FLAG: if (beat) begin
                mismatch = (rx_byte != TYPE_FLAG);
                if (cnt == 16'(FLAG_LEN - 1)) state_n = S_TIMESTAMP;
            end
            S_TIMESTAMP: if (beat && (cnt == 16'(TS_LEN - 1))) state_n = S_3ZEROS;
            S_3ZEROS: if (beat) begin
                mismatch = (rx_byte != 8'h00);
                if (cnt == 16'(ZEROS_LEN - 1)) state_n = S_PACKET_NUM;
            end
            S_PACKET_NUM: if (beat && (cnt == 16'(PNUM_LEN - 1))) begin
                pnum_commit = 1'b1;
                if (armed && (pnum_full != last_packet_num + 16'd1)) err_n.seq = 1'b1;
                state_n = S_DATA;
            end
            S_DATA: if (beat) begin
                mismatch = (rx_byte != data_byte(cnt[7:0]));
                // Overlong frame: flag it now, report it once its tlast is drained
                if (last_data && !s_eth_payload_axis_tlast) begin
                    err_n.len = 1'b1;
                    state_n   = S_DROP;
                end
            end
            S_DROP: if (beat && s_eth_payload_axis_tlast) begin
                state_n = S_IDLE;
                if (drain_report) begin
                    frame_end = 1'b1;
                    if (s_eth_payload_axis_tuser) err_n.frame = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (mismatch) err_n.data = 1'b1;
        if (parsing && beat && s_eth_payload_axis_tlast) begin
            state_n   = S_IDLE;
            frame_end = 1'b1;
            if (s_eth_payload_axis_tuser) err_n.frame = 1'b1;
            if (!last_data) err_n.len = 1'b1;
        end
    end

    assign frame_ok = frame_end && (err_n == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            err_q           <= '0;
            cnt             <= '0;
            ts_shift        <= '0;
            pnum_hi         <= '0;
            armed           <= 1'b0;
            drain_report    <= 1'b0;
            last_packet_num <= '0;
            last_timestamp  <= '0;
            pkt_done        <= 1'b0;
            pkt_ok          <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state <= state_n;
            err_q <= err_n;
            if (state_n != state) cnt <= '0;
            else if (beat)        cnt <= cnt + 16'd1;
            if (beat && (state == S_TIMESTAMP))  ts_shift <= {ts_shift[7:0], rx_byte};
            if (beat && (state == S_PACKET_NUM)) pnum_hi  <= rx_byte;
            drain_report <= (state_n == S_DROP) && (last_data || drain_report);
            if (pnum_commit) begin
                last_packet_num <= pnum_full;
                last_timestamp  <= ts_shift;
            end
            if (clear_counters)   armed <= 1'b0;
            else if (pnum_commit) armed <= 1'b1;
            pkt_done <= frame_end;
            pkt_ok   <= frame_ok;
        end
    end

    sat_counter #(.WIDTH(32)) u_good_cnt (
        .clk(clk), .rst(rst), .inc(frame_ok), .clr(clear_counters), .count(rx_good_count)
    );
    sat_counter #(.WIDTH(32)) u_seq_cnt (
        .clk(clk), .rst(rst), .inc(frame_end && err_n.seq), .clr(clear_counters),
        .count(err_seq_count)
    );
    sat_counter #(.WIDTH(32)) u_data_cnt (
        .clk(clk), .rst(rst), .inc(frame_end && err_n.data), .clr(clear_counters),
        .count(err_data_count)
    );
    sat_counter #(.WIDTH(32)) u_len_cnt (
        .clk(clk), .rst(rst), .inc(frame_end && err_n.len), .clr(clear_counters),
        .count(err_len_count)
    );
    sat_counter #(.WIDTH(32)) u_frame_cnt (
        .clk(clk), .rst(rst), .inc(frame_end && err_n.frame), .clr(clear_counters),
        .count(err_frame_count)
    );

endmodule
